// File: rtl/audio_mix_scheduler.sv
// audio_mix_scheduler
//   Mixes NUM_SRC signed audio sources into one master ring-buffer sample on every
//   advance of the player's sample_index. Each source is scaled by its volume, the
//   scaled terms are summed, and the sum is written LAG slots behind the play pointer.
//   Optional feature macro: MIX_SATURATE_EN (clip to the sample range instead of wrapping).
//
//   Source handshake: during the ACCUM cycle that visits source i, src_ack[i] is high
//   in that same cycle exactly when src_valid[i] is high; the sample and volume are
//   consumed on that clock edge. A visited source with src_valid low is skipped
//   (contributes 0, no ack) and raises the sticky underrun flag.
module audio_mix_scheduler #(
    parameter int NUM_SRC     = 2,
    parameter int SAMPLE_BITS = 16,
    parameter int VOLUME_BITS = 8,
    parameter int BUF_LEN     = 32,
    parameter int IDX_BITS    = 8,
    parameter int LAG         = 10
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [IDX_BITS-1:0]            sample_index,
    input  logic [NUM_SRC*SAMPLE_BITS-1:0] src_sample,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*VOLUME_BITS-1:0] src_vol,
    output logic [NUM_SRC-1:0]             src_ack,
    output logic                           wr_en,
    output logic [$clog2(BUF_LEN)-1:0]     wr_addr,
    output logic [SAMPLE_BITS-1:0]         wr_data,
    output logic                           busy,
    output logic                           underrun,
    output logic                           overrun,
    output logic [1:0]                     state_dbg
);

    localparam int AW    = $clog2(BUF_LEN);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ACC_W = SAMPLE_BITS + $clog2(NUM_SRC) + 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SRC - 1);
    // Adding BUF_LEN-LAG modulo BUF_LEN is the same as subtracting LAG with wrap.
    localparam logic [AW-1:0]    ADDR_OFF = AW'(BUF_LEN - LAG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_BITS-1:0]       idx_q;
    logic                      armed;
    logic [AW-1:0]             idx_t;
    logic [AW-1:0]             idx_pend;
    logic                      pending;
    logic [PTR_W-1:0]          src_ptr;
    logic signed [ACC_W-1:0]   acc;

    logic                      trigger;
    logic [SAMPLE_BITS-1:0]    sel_sample;
    logic [VOLUME_BITS-1:0]    sel_vol;
    logic                      sel_valid;
    logic signed [SAMPLE_BITS+VOLUME_BITS:0] prod;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_next;
    logic [SAMPLE_BITS-1:0]    clip_data;
    logic [AW-1:0]             addr_calc;

    // The first clock after reset only captures the index, so release never triggers.
    assign trigger   = armed && (sample_index != idx_q);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign addr_calc = idx_t + ADDR_OFF;

    // Select the source currently being visited.
    always_comb begin
        sel_sample = '0;
        sel_vol    = '0;
        sel_valid  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ptr == PTR_W'(i)) begin
                sel_sample = src_sample[i*SAMPLE_BITS +: SAMPLE_BITS];
                sel_vol    = src_vol[i*VOLUME_BITS +: VOLUME_BITS];
                sel_valid  = src_valid[i];
            end
        end
    end

    // Ack the visited source in the same cycle it is consumed.
    always_comb begin
        src_ack = '0;
        if (state == ACCUM) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_ptr == PTR_W'(i)) src_ack[i] = src_valid[i];
            end
        end
    end

    // Signed sample times unsigned volume; the arithmetic shift floors toward -inf.
    assign prod     = $signed(sel_sample) * $signed({1'b0, sel_vol});
    assign term     = sel_valid ? ACC_W'(prod >>> VOLUME_BITS) : '0;
    assign acc_next = acc + term;

`ifdef MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(SAMPLE_BITS-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the final sum into the representable sample range.
    always_comb begin
        if (acc_next > SAT_MAX)      clip_data = SAT_MAX[SAMPLE_BITS-1:0];
        else if (acc_next < SAT_MIN) clip_data = SAT_MIN[SAMPLE_BITS-1:0];
        else                         clip_data = acc_next[SAMPLE_BITS-1:0];
    end
`else
    // Two's-complement wrap: just keep the low sample bits.
    assign clip_data = acc_next[SAMPLE_BITS-1:0];
`endif

    // Scheduler FSM: trigger detection, accumulation, write strobe, pending/overrun tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            idx_q    <= '0;
            armed    <= 1'b0;
            idx_t    <= '0;
            idx_pend <= '0;
            pending  <= 1'b0;
            src_ptr  <= '0;
            acc      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            idx_q <= sample_index;
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        src_ptr <= '0;
                        idx_t   <= sample_index[AW-1:0];
                    end
                end
                ACCUM: begin
                    if (trigger) begin
                        pending  <= 1'b1;
                        idx_pend <= sample_index[AW-1:0];
                        if (pending) overrun <= 1'b1;
                    end
                    if (!sel_valid) underrun <= 1'b1;
                    acc <= acc_next;
                    if (src_ptr == LAST_PTR) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_calc;
                        wr_data <= clip_data;
                    end else begin
                        src_ptr <= src_ptr + 1'b1;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (pending || trigger) begin
                        // Queued (or just-arrived) index starts straight into ACCUM.
                        state   <= ACCUM;
                        acc     <= '0;
                        src_ptr <= '0;
                        pending <= 1'b0;
                        idx_t   <= trigger ? sample_index[AW-1:0] : idx_pend;
                        if (trigger && pending) overrun <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
